// File: rtl/decoder_bank.sv
// Bank of three registered one-hot decoders (1->2, 2->4, 3->8) sharing one enable.
// Optional one-hot violation flag `err` is built when DECODER_BANK_ONEHOT_CHK_EN is defined.

module decoder_bank_dec1 (
   input  logic       ena,
   input  logic       sel,
   output logic [1:0] out_c
);
   assign out_c[0] = ena & ~sel;
   assign out_c[1] = ena &  sel;
endmodule

module decoder_bank_dec2 (
   input  logic       ena,
   input  logic [1:0] sel,
   output logic [3:0] out_c
);
   decoder_bank_dec1 u_lo (.ena(ena & ~sel[1]), .sel(sel[0]), .out_c(out_c[1:0]));
   decoder_bank_dec1 u_hi (.ena(ena &  sel[1]), .sel(sel[0]), .out_c(out_c[3:2]));
endmodule

module decoder_bank_dec3 (
   input  logic       ena,
   input  logic [2:0] sel,
   output logic [7:0] out_c
);
   decoder_bank_dec2 u_lo (.ena(ena & ~sel[2]), .sel(sel[1:0]), .out_c(out_c[3:0]));
   decoder_bank_dec2 u_hi (.ena(ena &  sel[2]), .sel(sel[1:0]), .out_c(out_c[7:4]));
endmodule

module decoder_bank (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       in_1_to_2,
   input  logic [1:0] in_2_to_4,
   input  logic [2:0] in_3_to_8,
   output logic [1:0] out_1_to_2,
   output logic [3:0] out_2_to_4,
`ifdef DECODER_BANK_ONEHOT_CHK_EN
   output logic [7:0] out_3_to_8,
   output logic       err
`else
   output logic [7:0] out_3_to_8
`endif
);
   localparam int unsigned W1 = 2;
   localparam int unsigned W2 = 4;
   localparam int unsigned W3 = 8;

   logic [W1-1:0] dec1_c, out_1_to_2_d, out_1_to_2_q;
   logic [W2-1:0] dec2_c, out_2_to_4_d, out_2_to_4_q;
   logic [W3-1:0] dec3_c, out_3_to_8_d, out_3_to_8_q;

   decoder_bank_dec1 u_dec1 (.ena(ena), .sel(in_1_to_2), .out_c(dec1_c));
   decoder_bank_dec2 u_dec2 (.ena(ena), .sel(in_2_to_4), .out_c(dec2_c));
   decoder_bank_dec3 u_dec3 (.ena(ena), .sel(in_3_to_8), .out_c(dec3_c));

   // Reset dominates; the decoders already fold in ena.
   always_comb begin
      out_1_to_2_d = '0;
      out_2_to_4_d = '0;
      out_3_to_8_d = '0;
      if (!rst) begin
         out_1_to_2_d = dec1_c;
         out_2_to_4_d = dec2_c;
         out_3_to_8_d = dec3_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_1_to_2_q <= '0;
         out_2_to_4_q <= '0;
         out_3_to_8_q <= '0;
      end else begin
         out_1_to_2_q <= out_1_to_2_d;
         out_2_to_4_q <= out_2_to_4_d;
         out_3_to_8_q <= out_3_to_8_d;
      end
   end

   assign out_1_to_2 = out_1_to_2_q;
   assign out_2_to_4 = out_2_to_4_q;
   assign out_3_to_8 = out_3_to_8_q;

`ifdef DECODER_BANK_ONEHOT_CHK_EN
   logic err_d, err_q;

   // More than one bit set iff clearing the lowest set bit leaves something behind.
   function automatic logic multi_hot(input logic [W3-1:0] v);
      return (v & (v - W3'(1))) != '0;
   endfunction

   always_comb begin
      err_d = 1'b0;
      if (!rst) begin
         err_d = multi_hot(W3'(out_1_to_2_d)) |
                 multi_hot(W3'(out_2_to_4_d)) |
                 multi_hot(out_3_to_8_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_decoder_bank.sv
// Directed and random self-checking bench for decoder_bank.
// Build with DECODER_BANK_ONEHOT_CHK_EN defined to also check the err flag.

module tb_decoder_bank;
   logic       clk = 1'b0;
   logic       rst, ena, in_1_to_2;
   logic [1:0] in_2_to_4;
   logic [2:0] in_3_to_8;
   logic [1:0] out_1_to_2;
   logic [3:0] out_2_to_4;
   logic [7:0] out_3_to_8;
`ifdef DECODER_BANK_ONEHOT_CHK_EN
   logic       err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   decoder_bank dut (
      .clk(clk), .rst(rst), .ena(ena),
      .in_1_to_2(in_1_to_2), .in_2_to_4(in_2_to_4), .in_3_to_8(in_3_to_8),
      .out_1_to_2(out_1_to_2), .out_2_to_4(out_2_to_4),
`ifdef DECODER_BANK_ONEHOT_CHK_EN
      .out_3_to_8(out_3_to_8), .err(err)
`else
      .out_3_to_8(out_3_to_8)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive inputs, then advance past the next rising edge.
   task automatic step(input logic r, input logic e, input logic a,
                       input logic [1:0] b, input logic [2:0] c);
      rst = r; ena = e; in_1_to_2 = a; in_2_to_4 = b; in_3_to_8 = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag, input logic r, input logic e,
                              input logic a, input logic [1:0] b, input logic [2:0] c);
      logic [7:0] e1, e2, e3;
      logic       act;
      act = !r && e;
      e1 = act ? (8'd1 << a) : 8'd0;
      e2 = act ? (8'd1 << b) : 8'd0;
      e3 = act ? (8'd1 << c) : 8'd0;
      check({tag, ".o12"}, 8'(out_1_to_2), e1);
      check({tag, ".o24"}, 8'(out_2_to_4), e2);
      check({tag, ".o38"}, out_3_to_8, e3);
`ifdef DECODER_BANK_ONEHOT_CHK_EN
      check({tag, ".err"}, 8'(err), 8'd0);
`endif
   endtask

   initial begin
      logic       r, e, a;
      logic [1:0] b;
      logic [2:0] c;

      // Reset holds every output at zero regardless of ena and selects.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b1, 2'd3, 3'd7);
         check("rst.o12", 8'(out_1_to_2), 8'h00);
         check("rst.o24", 8'(out_2_to_4), 8'h00);
         check("rst.o38", out_3_to_8, 8'h00);
`ifdef DECODER_BANK_ONEHOT_CHK_EN
         check("rst.err", 8'(err), 8'h00);
`endif
      end

      // Disabled: outputs stay zero for any select.
      for (int i = 0; i < 100; i++) begin
         step(1'b0, 1'b0, 1'($urandom), 2'($urandom), 3'($urandom));
         check("dis.o12", 8'(out_1_to_2), 8'h00);
         check("dis.o24", 8'(out_2_to_4), 8'h00);
         check("dis.o38", out_3_to_8, 8'h00);
      end

      // Hand-computed directed vector.
      step(1'b0, 1'b1, 1'b1, 2'd2, 3'd5);
      check("dir.o12", 8'(out_1_to_2), 8'h02);
      check("dir.o24", 8'(out_2_to_4), 8'h04);
      check("dir.o38", out_3_to_8, 8'h20);

      // Boundaries.
      step(1'b0, 1'b1, 1'b0, 2'd0, 3'd0);
      check("lo.o12", 8'(out_1_to_2), 8'h01);
      check("lo.o24", 8'(out_2_to_4), 8'h01);
      check("lo.o38", out_3_to_8, 8'h01);
      step(1'b0, 1'b1, 1'b1, 2'd3, 3'd7);
      check("hi.o12", 8'(out_1_to_2), 8'h02);
      check("hi.o24", 8'(out_2_to_4), 8'h08);
      check("hi.o38", out_3_to_8, 8'h80);

      // Exhaustive sweep with independent select orderings.
      for (int i = 0; i < 8; i++) begin
         a = 1'(i); b = 2'(3 - (i % 4)); c = 3'(i);
         step(1'b0, 1'b1, a, b, c);
         check_model("sweep", 1'b0, 1'b1, a, b, c);
      end

      // Reset pulse mid-stream with ena held high.
      step(1'b0, 1'b1, 1'b1, 2'd1, 3'd6);
      check("pre.o38", out_3_to_8, 8'h40);
      step(1'b1, 1'b1, 1'b0, 2'd2, 3'd3);
      check("mid.o12", 8'(out_1_to_2), 8'h00);
      check("mid.o24", 8'(out_2_to_4), 8'h00);
      check("mid.o38", out_3_to_8, 8'h00);
      step(1'b0, 1'b1, 1'b0, 2'd2, 3'd3);
      check("post.o12", 8'(out_1_to_2), 8'h01);
      check("post.o24", 8'(out_2_to_4), 8'h04);
      check("post.o38", out_3_to_8, 8'h08);

      // Random traffic against the model plus the one-hot invariant.
      for (int i = 0; i < 2000; i++) begin
         r = ($urandom_range(0, 31) == 0);
         e = 1'($urandom);
         a = 1'($urandom); b = 2'($urandom); c = 3'($urandom);
         step(r, e, a, b, c);
         check_model("rnd", r, e, a, b, c);
         check("rnd.onehot", 8'($countones(out_3_to_8) <= 1), 8'h01);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
